regfile_wb_queue: RTL and testbench

//  Writer-side driver for the 32x32 register file write port (wr_en/wr_addr/wr_data).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wbq_fifo.sv | 72 +++++++
 rtl/regfile_wb_queue.sv | 135 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths and the writeback entry type for the regfile
//                write-port driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wbq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wbq_fifo
//  Description : 2-push / 1-pop circular buffer of writeback entries, with
//                every slot exposed in age order (index 0 = head).
//  Revision    : 1.0 - initial release
// ============================================================================
module wbq_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push0,
    input  wb_entry_t              i_entry0,
    input  logic                   i_push1,
    input  wb_entry_t              i_entry1,
    input  logic                   i_pop,
    output wb_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [DEPTH-1:0]       o_age_valid,
    output wb_entry_t              o_age_entry [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] w_idx1;

    // Slot 1 lands right after slot 0 only when slot 0 is actually used.
    assign w_idx1 = r_wr_ptr + PTR_W'(i_push0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push0) + PTR_W'(i_push1);
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push0) begin
            r_mem[r_wr_ptr] <= i_entry0;
        end
        if (i_push1) begin
            r_mem[w_idx1] <= i_entry1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_age_entry[i] = r_mem[r_rd_ptr + PTR_W'(i)];
            o_age_valid[i] = (CNT_W'(i) < r_count);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_queue
//  Description : Merges MEM/ALU writebacks into an in-order queue, drains one
//                register-file write per cycle and offers a decode bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   elk,
    input  logic                   nrst,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    input  logic [ADDR_W-1:0]      byp_addrA,
    input  logic [ADDR_W-1:0]      byp_addrB,
    output logic                   byp_hitA,
    output logic [DATA_W-1:0]      byp_dataA,
    output logic                   byp_hitB,
    output logic [DATA_W-1:0]      byp_dataB,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DEPTH - 1);

    logic              w_mem_push;
    logic              w_alu_push;
    logic              w_pop;
    wb_entry_t         w_mem_entry;
    wb_entry_t         w_alu_entry;
    wb_entry_t         w_head;
    logic [CNT_W-1:0]  w_count;
    logic [DEPTH-1:0]  w_age_valid;
    wb_entry_t         w_age_entry [DEPTH];

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    // Readiness reserves room for both sources against the registered count
    // only, so it never relies on the drain happening in the same cycle.
    assign mem_ready = !nrst && (w_count < c_full);
    assign alu_ready = !nrst && ((w_count < c_last) || ((w_count == c_last) && !mem_valid));

    assign w_mem_push  = mem_valid && mem_ready && (mem_addr != REG_ZERO);
    assign w_alu_push  = alu_valid && alu_ready && (alu_addr != REG_ZERO);
    assign w_mem_entry = {mem_addr, mem_data};
    assign w_alu_entry = {alu_addr, alu_data};
    assign w_pop       = (w_count != '0);

    // MEM is the older producer, so it takes the first push slot.
    wbq_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (elk),
        .rst         (nrst),
        .i_push0     (w_mem_push),
        .i_entry0    (w_mem_entry),
        .i_push1     (w_alu_push),
        .i_entry1    (w_alu_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_age_valid (w_age_valid),
        .o_age_entry (w_age_entry)
    );

    always_ff @(posedge elk) begin
        if (nrst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_pop) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_head.addr;
            r_wr_data <= w_head.data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Oldest first, later matches overwrite: wr_* stage, then head .. youngest.
    always_comb begin
        byp_hitA  = 1'b0;
        byp_dataA = '0;
        byp_hitB  = 1'b0;
        byp_dataB = '0;
        if (r_wr_en && (r_wr_addr == byp_addrA)) begin
            byp_hitA  = 1'b1;
            byp_dataA = r_wr_data;
        end
        if (r_wr_en && (r_wr_addr == byp_addrB)) begin
            byp_hitB  = 1'b1;
            byp_dataB = r_wr_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_age_valid[i] && (w_age_entry[i].addr == byp_addrA)) begin
                byp_hitA  = 1'b1;
                byp_dataA = w_age_entry[i].data;
            end
            if (w_age_valid[i] && (w_age_entry[i].addr == byp_addrB)) begin
                byp_hitB  = 1'b1;
                byp_dataB = w_age_entry[i].data;
            end
        end
        if (byp_addrA == REG_ZERO) begin
            byp_hitA  = 1'b0;
            byp_dataA = '0;
        end
        if (byp_addrB == REG_ZERO) begin
            byp_hitB  = 1'b0;
            byp_dataB = '0;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign count   = w_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_queue
//  Description : Self-checking bench for regfile_wb_queue against a queue-based
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic        elk, nrst;
    logic        mem_valid, mem_ready, alu_valid, alu_ready;
    logic [4:0]  mem_addr, alu_addr, wr_addr, byp_addrA, byp_addrB;
    logic [31:0] mem_data, alu_data, wr_data, byp_dataA, byp_dataB;
    logic        wr_en, byp_hitA, byp_hitB;
    logic [2:0]  count;

    // Second instance with DEPTH=2, where a completely full queue is reachable.
    logic        s_mem_valid, s_mem_ready, s_alu_valid, s_alu_ready;
    logic [4:0]  s_mem_addr, s_alu_addr, s_wr_addr, s_byp_addrA, s_byp_addrB;
    logic [31:0] s_mem_data, s_alu_data, s_wr_data, s_byp_dataA, s_byp_dataB;
    logic        s_wr_en, s_byp_hitA, s_byp_hitB;
    logic [1:0]  s_count;

    int total = 0;
    int bad   = 0;

    wb_entry_t   m_q[$];
    logic        m_wr_en;
    logic [4:0]  m_wr_addr;
    logic [31:0] m_wr_data;

    regfile_wb_queue #(.DEPTH(DEPTH)) u_dut (
        .elk(elk), .nrst(nrst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .byp_addrA(byp_addrA), .byp_addrB(byp_addrB),
        .byp_hitA(byp_hitA), .byp_dataA(byp_dataA), .byp_hitB(byp_hitB), .byp_dataB(byp_dataB),
        .count(count)
    );

    regfile_wb_queue #(.DEPTH(2)) u_dut2 (
        .elk(elk), .nrst(nrst),
        .mem_valid(s_mem_valid), .mem_ready(s_mem_ready), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
        .alu_valid(s_alu_valid), .alu_ready(s_alu_ready), .alu_addr(s_alu_addr), .alu_data(s_alu_data),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .byp_addrA(s_byp_addrA), .byp_addrB(s_byp_addrB),
        .byp_hitA(s_byp_hitA), .byp_dataA(s_byp_dataA), .byp_hitB(s_byp_hitB), .byp_dataB(s_byp_dataB),
        .count(s_count)
    );

    initial elk = 1'b0;
    always #5 elk = ~elk;

    // Room check: MEM needs one free slot, ALU needs one beyond what MEM may take.
    function automatic logic exp_mem_rdy();
        return !nrst && (m_q.size() < DEPTH);
    endfunction

    function automatic logic exp_alu_rdy();
        return !nrst && ((m_q.size() + int'(mem_valid)) < DEPTH);
    endfunction

    task automatic model_byp(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 5'd0) begin
            if (m_wr_en && m_wr_addr == a) begin h = 1'b1; d = m_wr_data; end
            foreach (m_q[i]) if (m_q[i].addr == a) begin h = 1'b1; d = m_q[i].data; end
        end
    endtask

    // One rising edge; the model follows the rules with the inputs as driven.
    task automatic tick();
        logic ma, aa;
        wb_entry_t me, ae;
        ma = mem_valid && exp_mem_rdy();
        aa = alu_valid && exp_alu_rdy();
        me = {mem_addr, mem_data};
        ae = {alu_addr, alu_data};
        @(posedge elk);
        if (nrst) begin
            m_q.delete();
            m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
        end else begin
            if (m_q.size() > 0) begin
                wb_entry_t e;
                e = m_q.pop_front();
                m_wr_en = 1'b1; m_wr_addr = e.addr; m_wr_data = e.data;
            end else begin
                m_wr_en = 1'b0;
            end
            if (ma && me.addr != 5'd0) m_q.push_back(me);
            if (aa && ae.addr != 5'd0) m_q.push_back(ae);
        end
        #1;
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0; alu_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        nrst = 1'b1; byp_addrA = 5'd5; byp_addrB = 5'd0;
        tick(); tick();
        @(negedge elk);
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%0h exp=0", mem_ready); end
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%0h exp=0", alu_ready); end
        total++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin bad++; $display("FAIL rst_wr got=%0h/%0h exp=0/0", wr_addr, wr_data); end
        nrst = 1'b0;
        tick();
        @(negedge elk);
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL idle_wr_en got=%0h exp=0", wr_en); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL idle_count got=%0d exp=0", count); end
        total++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0h/%0h exp=1/1", mem_ready, alu_ready); end
        total++; if (byp_hitA !== 1'b0) begin bad++; $display("FAIL idle_hitA got=%0h exp=0", byp_hitA); end
    endtask

    task automatic test_single_alu();
        idle(2);
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEADBEEF; byp_addrA = 5'd3;
        @(negedge elk);
        total++; if (alu_ready !== 1'b1 || byp_hitA !== 1'b0) begin bad++; $display("FAIL single_pre got=%0h/%0h exp=1/0", alu_ready, byp_hitA); end
        tick();
        alu_valid = 1'b0;
        @(negedge elk);
        total++; if (byp_hitA !== 1'b1 || byp_dataA !== 32'hDEADBEEF) begin bad++; $display("FAIL single_byp_q got=%0h/%0h exp=1/deadbeef", byp_hitA, byp_dataA); end
        total++; if (wr_en !== 1'b0 || count !== 3'd1) begin bad++; $display("FAIL single_q got=%0h/%0d exp=0/1", wr_en, count); end
        tick();
        @(negedge elk);
        total++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wr got=%0h/%0d/%0h exp=1/3/deadbeef", wr_en, wr_addr, wr_data); end
        total++; if (byp_hitA !== 1'b1 || byp_dataA !== 32'hDEADBEEF) begin bad++; $display("FAIL single_byp_wr got=%0h/%0h exp=1/deadbeef", byp_hitA, byp_dataA); end
        tick();
        @(negedge elk);
        total++; if (wr_en !== 1'b0 || byp_hitA !== 1'b0) begin bad++; $display("FAIL single_after got=%0h/%0h exp=0/0", wr_en, byp_hitA); end
    endtask

    task automatic test_same_cycle();
        idle(2);
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h11;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h22;
        byp_addrA = 5'd4; byp_addrB = 5'd0;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        @(negedge elk);
        total++; if (count !== 3'd2 || byp_hitA !== 1'b1 || byp_dataA !== 32'h22) begin bad++; $display("FAIL same_newest got=%0d/%0h/%0h exp=2/1/22", count, byp_hitA, byp_dataA); end
        total++; if (byp_hitB !== 1'b0 || byp_dataB !== 32'd0) begin bad++; $display("FAIL same_r0 got=%0h/%0h exp=0/0", byp_hitB, byp_dataB); end
        tick();
        @(negedge elk);
        total++; if (wr_en !== 1'b1 || wr_data !== 32'h11 || byp_dataA !== 32'h22) begin bad++; $display("FAIL same_first got=%0h/%0h/%0h exp=1/11/22", wr_en, wr_data, byp_dataA); end
        tick();
        @(negedge elk);
        total++; if (wr_en !== 1'b1 || wr_data !== 32'h22 || count !== 3'd0) begin bad++; $display("FAIL same_second got=%0h/%0h/%0d exp=1/22/0", wr_en, wr_data, count); end
    endtask

    task automatic test_fill();
        logic aacc;
        idle(3);
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = $urandom;
        for (int k = 0; k < 5; k++) begin
            mem_valid = 1'b1; mem_addr = 5'(1 + 2 * k); mem_data = $urandom;
            @(negedge elk);
            total++; if (count !== 3'(m_q.size())) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, m_q.size()); end
            total++; if (mem_ready !== exp_mem_rdy() || alu_ready !== exp_alu_rdy()) begin bad++; $display("FAIL fill_ready got=%0h/%0h exp=%0h/%0h", mem_ready, alu_ready, exp_mem_rdy(), exp_alu_rdy()); end
            if (m_q.size() == DEPTH - 1) begin
                total++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin bad++; $display("FAIL fill_last_slot got=%0h/%0h exp=1/0", mem_ready, alu_ready); end
            end
            aacc = exp_alu_rdy();
            tick();
            if (aacc) begin alu_addr = 5'(2 + 2 * k); alu_data = $urandom; end
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        @(negedge elk);
        total++; if (count !== 3'(DEPTH - 1)) begin bad++; $display("FAIL fill_stable got=%0d exp=%0d", count, DEPTH - 1); end
        idle(6);
    endtask

    task automatic test_r0();
        idle(4);
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h55; byp_addrA = 5'd0;
        @(negedge elk);
        total++; if (mem_ready !== 1'b1 || byp_hitA !== 1'b0) begin bad++; $display("FAIL r0_hs got=%0h/%0h exp=1/0", mem_ready, byp_hitA); end
        tick();
        mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge elk);
            total++; if (count !== 3'd0 || wr_en !== 1'b0 || byp_hitA !== 1'b0) begin bad++; $display("FAIL r0_drop got=%0d/%0h/%0h exp=0/0/0", count, wr_en, byp_hitA); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle(4);
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h6;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h7;
        tick();
        mem_addr = 5'd8; mem_data = 32'h8; alu_addr = 5'd9; alu_data = 32'h9;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        @(negedge elk);
        total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_prefill got=%0d exp=3", count); end
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        @(negedge elk);
        total++; if (wr_en !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL mid_reset got=%0h/%0d exp=0/0", wr_en, count); end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge elk);
            total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_no_pulse got=%0h exp=0", wr_en); end
        end
    endtask

    task automatic test_full_depth2();
        idle(2);
        s_mem_valid = 1'b1; s_mem_addr = 5'd1; s_mem_data = 32'hA;
        s_alu_valid = 1'b1; s_alu_addr = 5'd2; s_alu_data = 32'hB;
        @(negedge elk);
        total++; if (s_mem_ready !== 1'b1 || s_alu_ready !== 1'b1) begin bad++; $display("FAIL d2_empty_ready got=%0h/%0h exp=1/1", s_mem_ready, s_alu_ready); end
        tick();
        s_mem_valid = 1'b0; s_alu_valid = 1'b0;
        @(negedge elk);
        total++; if (s_count !== 2'd2 || s_mem_ready !== 1'b0 || s_alu_ready !== 1'b0) begin bad++; $display("FAIL d2_full got=%0d/%0h/%0h exp=2/0/0", s_count, s_mem_ready, s_alu_ready); end
        tick();
        @(negedge elk);
        total++; if (s_wr_en !== 1'b1 || s_wr_addr !== 5'd1 || s_count !== 2'd1) begin bad++; $display("FAIL d2_drain got=%0h/%0d/%0d exp=1/1/1", s_wr_en, s_wr_addr, s_count); end
        idle(3);
    endtask

    task automatic test_random();
        logic macc, aacc, eh;
        logic [31:0] ed;
        macc = 1'b1; aacc = 1'b1;
        mem_valid = 1'b0; alu_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            // A stalled request stays put until it is taken.
            if (!mem_valid || macc) begin
                mem_valid = ($urandom_range(0, 9) < 6); mem_addr = 5'($urandom_range(0, 7)); mem_data = $urandom;
            end
            if (!alu_valid || aacc) begin
                alu_valid = ($urandom_range(0, 9) < 6); alu_addr = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            byp_addrA = 5'($urandom_range(0, 7));
            byp_addrB = 5'($urandom_range(0, 7));
            @(negedge elk);
            total++; if (mem_ready !== exp_mem_rdy()) begin bad++; $display("FAIL rnd_mem_ready c=%0d got=%0h exp=%0h", c, mem_ready, exp_mem_rdy()); end
            total++; if (alu_ready !== exp_alu_rdy()) begin bad++; $display("FAIL rnd_alu_ready c=%0d got=%0h exp=%0h", c, alu_ready, exp_alu_rdy()); end
            total++; if (count !== 3'(m_q.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, m_q.size()); end
            total++; if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin bad++; $display("FAIL rnd_wr c=%0d got=%0h/%0d/%0h exp=%0h/%0d/%0h", c, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data); end
            model_byp(byp_addrA, eh, ed);
            total++; if (byp_hitA !== eh || byp_dataA !== ed) begin bad++; $display("FAIL rnd_bypA c=%0d got=%0h/%0h exp=%0h/%0h", c, byp_hitA, byp_dataA, eh, ed); end
            model_byp(byp_addrB, eh, ed);
            total++; if (byp_hitB !== eh || byp_dataB !== ed) begin bad++; $display("FAIL rnd_bypB c=%0d got=%0h/%0h exp=%0h/%0h", c, byp_hitB, byp_dataB, eh, ed); end
            macc = exp_mem_rdy();
            aacc = exp_alu_rdy();
            tick();
        end
        idle(6);
    endtask

    initial begin
        nrst = 1'b1;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        byp_addrA = '0; byp_addrB = '0;
        s_mem_valid = 1'b0; s_mem_addr = '0; s_mem_data = '0;
        s_alu_valid = 1'b0; s_alu_addr = '0; s_alu_data = '0;
        s_byp_addrA = '0; s_byp_addrB = '0;
        m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
        #1;
        test_reset();
        test_single_alu();
        test_same_cycle();
        test_fill();
        test_r0();
        test_reset_mid();
        test_full_depth2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
